nonce_sweeper: RTL and testbench



---
 rtl/mining_pkg.sv | 26 ++
 rtl/target_compare.sv | 21 ++
 rtl/nonce_sweeper.sv | 143 ++++++++++++++
 tb/tb_nonce_sweeper.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mining_pkg.sv
// Shared types, header geometry and byte-order helpers for the mining datapath.
package mining_pkg;

  typedef enum logic [1:0] {
    EXHAUSTED = 2'd0,
    FOUND     = 2'd1,
    ABORTED   = 2'd2
  } sweep_status_t;

  localparam int PREFIX_W = 608;
  localparam int HEADER_W = 640;
  localparam int DIGEST_W = 256;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [DIGEST_W-1:0] bswap256(input logic [DIGEST_W-1:0] x);
    logic [DIGEST_W-1:0] y;
    for (int i = 0; i < 32; i++) begin
      y[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return y;
  endfunction

endpackage

// File: rtl/target_compare.sv
// Registered digest-vs-target check; the digest arrives big-endian, so byte 31
// becomes the most significant byte of the value compared against the target.
module target_compare
  import mining_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGEST_W-1:0] digest,
  input  logic [DIGEST_W-1:0] target,
  output logic                hit
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
    end else begin
      hit <= (bswap256(digest) <= target);
    end
  end

endmodule

// File: rtl/nonce_sweeper.sv
// Job-level driver for one double-SHA-256 hasher: sweeps an inclusive nonce
// range, checks every digest against the target and reports hits and job end.
module nonce_sweeper
  import mining_pkg::*;
#(
  parameter bit STOP_ON_FOUND = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [PREFIX_W-1:0] job_prefix,
  input  logic [DIGEST_W-1:0] job_target,
  input  logic [31:0]         job_nonce_start,
  input  logic [31:0]         job_nonce_end,
  input  logic                abort,
  output logic                hasher_start,
  output logic [HEADER_W-1:0] hasher_header,
  input  logic                hasher_ready,
  input  logic [DIGEST_W-1:0] hasher_hash,
  input  logic                hasher_valid,
  output logic                found_valid,
  output logic [31:0]         found_nonce,
  output logic [DIGEST_W-1:0] found_hash,
  output logic                done_valid,
  output logic [1:0]          done_status,
  output logic [CNT_W-1:0]    hashes_done,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, FINISH} state_t;

  state_t              state;
  logic [PREFIX_W-1:0] prefix_reg;
  logic [DIGEST_W-1:0] target_reg;
  logic [DIGEST_W-1:0] digest_reg;
  logic [31:0]         nonce_reg;
  logic [31:0]         end_reg;
  logic                abort_flag;
  logic                any_hit;
  logic                hit;
  sweep_status_t       finish_status;

  target_compare u_cmp (
    .clk    (clk),
    .rst    (rst),
    .digest (hasher_hash),
    .target (target_reg),
    .hit    (hit)
  );

  // The start pulse must coincide with hasher_ready, and an abort seen in ISSUE
  // must win before anything is launched, so start is decoded from live inputs.
  assign hasher_start  = (state == ISSUE) && hasher_ready && !abort;
  assign hasher_header = {prefix_reg, bswap32(nonce_reg)};
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      job_ready     <= 1'b1;
      prefix_reg    <= '0;
      target_reg    <= '0;
      digest_reg    <= '0;
      nonce_reg     <= '0;
      end_reg       <= '0;
      abort_flag    <= 1'b0;
      any_hit       <= 1'b0;
      finish_status <= EXHAUSTED;
      found_valid   <= 1'b0;
      found_nonce   <= '0;
      found_hash    <= '0;
      done_valid    <= 1'b0;
      done_status   <= 2'd0;
      hashes_done   <= '0;
    end else begin
      found_valid <= 1'b0;
      done_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid && job_ready) begin
            prefix_reg  <= job_prefix;
            target_reg  <= job_target;
            nonce_reg   <= job_nonce_start;
            end_reg     <= job_nonce_end;
            hashes_done <= '0;
            abort_flag  <= 1'b0;
            any_hit     <= 1'b0;
            job_ready   <= 1'b0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (abort) begin
            finish_status <= ABORTED;
            state         <= FINISH;
          end else if (hasher_ready) begin
            state <= WAIT;
          end
        end
        // An abort here cannot cancel the hasher, so remember it and drain the digest.
        WAIT: begin
          if (abort) abort_flag <= 1'b1;
          if (hasher_valid) begin
            digest_reg  <= hasher_hash;
            hashes_done <= hashes_done + CNT_W'(1);
            state       <= CHECK;
          end
        end
        CHECK: begin
          if (abort_flag || abort) begin
            finish_status <= ABORTED;
            state         <= FINISH;
          end else begin
            if (hit) begin
              found_valid <= 1'b1;
              found_nonce <= nonce_reg;
              found_hash  <= digest_reg;
              any_hit     <= 1'b1;
            end
            if ((hit && STOP_ON_FOUND) || (nonce_reg == end_reg)) begin
              finish_status <= (hit || any_hit) ? FOUND : EXHAUSTED;
              state         <= FINISH;
            end else begin
              nonce_reg <= nonce_reg + 32'd1;
              state     <= ISSUE;
            end
          end
        end
        // done_valid lands one cycle after any found_valid from CHECK, never with it.
        FINISH: begin
          done_valid  <= 1'b1;
          done_status <= finish_status;
          job_ready   <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// Directed bench: two sweepers (stop-on-found and sweep-all), each fed by a
// behavioural hasher whose digests are keyed on the header nonce field.
module tb_nonce_sweeper;

  localparam int LAT    = 6;
  localparam int BUDGET = 400;

  localparam logic [607:0] GEN_PREFIX = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49,
    32'hffff001d
  };
  localparam logic [255:0] GEN_TARGET = 256'hffff << 208;
  localparam logic [255:0] GEN_DIGEST =
    256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
  localparam logic [255:0] ALL_ONES = {256{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic hold_ready = 1'b0;
  logic [607:0] job_prefix = '0;
  logic [255:0] job_target = '0;
  logic [31:0]  job_nonce_start = '0;
  logic [31:0]  job_nonce_end = '0;

  logic [1:0]        job_valid = '0;
  logic [1:0]        job_ready, hasher_start, hasher_ready, found_valid, done_valid, busy;
  logic [1:0]        h_ready = 2'b11;
  logic [1:0]        hasher_valid = '0;
  logic [1:0][639:0] hasher_header;
  logic [1:0][255:0] hasher_hash = '0;
  logic [1:0][255:0] found_hash;
  logic [1:0][31:0]  found_nonce, hashes_done;
  logic [1:0][1:0]   done_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hasher_ready[0] = h_ready[0] && !hold_ready;
  assign hasher_ready[1] = h_ready[1] && !hold_ready;

  nonce_sweeper #(.STOP_ON_FOUND(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .job_valid(job_valid[0]), .job_ready(job_ready[0]),
    .job_prefix(job_prefix), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .abort(abort),
    .hasher_start(hasher_start[0]), .hasher_header(hasher_header[0]),
    .hasher_ready(hasher_ready[0]), .hasher_hash(hasher_hash[0]),
    .hasher_valid(hasher_valid[0]),
    .found_valid(found_valid[0]), .found_nonce(found_nonce[0]),
    .found_hash(found_hash[0]),
    .done_valid(done_valid[0]), .done_status(done_status[0]),
    .hashes_done(hashes_done[0]), .busy(busy[0])
  );

  nonce_sweeper #(.STOP_ON_FOUND(1'b0), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .job_valid(job_valid[1]), .job_ready(job_ready[1]),
    .job_prefix(job_prefix), .job_target(job_target),
    .job_nonce_start(job_nonce_start), .job_nonce_end(job_nonce_end),
    .abort(abort),
    .hasher_start(hasher_start[1]), .hasher_header(hasher_header[1]),
    .hasher_ready(hasher_ready[1]), .hasher_hash(hasher_hash[1]),
    .hasher_valid(hasher_valid[1]),
    .found_valid(found_valid[1]), .found_nonce(found_nonce[1]),
    .found_hash(found_hash[1]),
    .done_valid(done_valid[1]), .done_status(done_status[1]),
    .hashes_done(hashes_done[1]), .busy(busy[1])
  );

  // Only the genesis nonce yields a winning digest; every other digest has a
  // non-zero last byte, which makes its value far above any realistic target.
  function automatic logic [255:0] fake_digest(input logic [639:0] h);
    if (h[31:0] == 32'h1dac2b7c) return GEN_DIGEST;
    return {h[31:0], 216'h0, 8'ha5};
  endfunction

  // Behavioural hasher per sweeper: fixed latency, header captured at start.
  int               h_cnt [2] = '{0, 0};
  logic [1:0]       h_busy = '0;
  logic [639:0]     h_hdr [2];
  int               start_cnt [2] = '{0, 0};
  int               header_viol = 0;
  int               proto_viol = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        h_busy[k]       <= 1'b0;
        h_ready[k]      <= 1'b1;
        hasher_valid[k] <= 1'b0;
        h_cnt[k]        <= 0;
      end else begin
        hasher_valid[k] <= 1'b0;
        if (hasher_start[k]) begin
          if (!hasher_ready[k] || h_busy[k]) proto_viol <= proto_viol + 1;
          start_cnt[k] <= start_cnt[k] + 1;
          h_busy[k]    <= 1'b1;
          h_ready[k]   <= 1'b0;
          h_cnt[k]     <= LAT;
          h_hdr[k]     <= hasher_header[k];
        end else if (h_busy[k]) begin
          if (hasher_header[k] !== h_hdr[k]) header_viol <= header_viol + 1;
          if (h_cnt[k] == 1) begin
            h_busy[k]       <= 1'b0;
            h_ready[k]      <= 1'b1;
            hasher_valid[k] <= 1'b1;
            hasher_hash[k]  <= fake_digest(h_hdr[k]);
          end else begin
            h_cnt[k] <= h_cnt[k] - 1;
          end
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  int           cyc = 0;
  int           last_valid_cyc [2] = '{0, 0};
  int           found_lat [2] = '{0, 0};
  int           fcount [2] = '{0, 0};
  logic [31:0]  fn [2][8];
  logic [255:0] fh [2];
  int           both_viol = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (hasher_valid[k]) last_valid_cyc[k] <= cyc;
      if (found_valid[k] && done_valid[k]) both_viol <= both_viol + 1;
      if (found_valid[k]) begin
        if (fcount[k] < 8) fn[k][fcount[k]] <= found_nonce[k];
        fcount[k]    <= fcount[k] + 1;
        fh[k]        <= found_hash[k];
        found_lat[k] <= cyc - last_valid_cyc[k];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [639:0] actual,
                             input logic [639:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  int fbase;
  int sbase;

  // Offers one job at a falling edge; returns one cycle later, after acceptance.
  task automatic applyStimulus(input int k, input logic [607:0] prefix,
                               input logic [255:0] target,
                               input logic [31:0] ns, input logic [31:0] ne);
    job_prefix      = prefix;
    job_target      = target;
    job_nonce_start = ns;
    job_nonce_end   = ne;
    fbase           = fcount[k];
    sbase           = start_cnt[k];
    job_valid[k]    = 1'b1;
    @(negedge clk);
    job_valid[k]    = 1'b0;
  endtask

  task automatic waitDone(input int k);
    int n = 0;
    while (done_valid[k] !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_in_budget", n < BUDGET, 1'b1);
  endtask

  task automatic waitStart(input int k);
    int n = 0;
    while (hasher_start[k] !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    checkOutput("start_in_budget", n < BUDGET, 1'b1);
  endtask

  logic [31:0] t3_exp [4] = '{32'hffffffff - 32'd1, 32'hffffffff, 32'h0, 32'h1};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic saw_done;
    repeat (3) @(negedge clk);

    checkOutput("rst_job_ready", job_ready[0], 1'b1);
    checkOutput("rst_busy", busy[0], 1'b0);
    checkOutput("rst_found_valid", found_valid[0], 1'b0);
    checkOutput("rst_done_valid", done_valid[0], 1'b0);
    checkOutput("rst_hasher_start", hasher_start[0], 1'b0);
    checkOutput("rst_hashes_done", hashes_done[0], 32'd0);
    checkOutput("rst_done_status", done_status[0], 2'd0);
    checkOutput("rst_found_nonce", found_nonce[0], 32'd0);
    checkOutput("rst_header", hasher_header[0], 640'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: genesis hit, stop on found");
    applyStimulus(0, GEN_PREFIX, GEN_TARGET, 32'h7c2bac1b, 32'h7c2bac1f);
    checkOutput("t1_first_start", hasher_start[0], 1'b1);
    checkOutput("t1_header", hasher_header[0], {GEN_PREFIX, 32'h1bac2b7c});
    checkOutput("t1_busy", busy[0], 1'b1);
    checkOutput("t1_job_ready", job_ready[0], 1'b0);
    waitDone(0);
    checkOutput("t1_status", done_status[0], 2'd1);
    checkOutput("t1_hashes", hashes_done[0], 32'd3);
    checkOutput("t1_found_count", fcount[0] - fbase, 1);
    checkOutput("t1_found_nonce", fn[0][fbase], 32'h7c2bac1d);
    checkOutput("t1_found_hash", fh[0], GEN_DIGEST);
    checkOutput("t1_found_latency", found_lat[0], 2);
    checkOutput("t1_starts", start_cnt[0] - sbase, 3);
    @(negedge clk);

    $display("[TB] test 2: range past the hit, exhausted");
    applyStimulus(0, GEN_PREFIX, GEN_TARGET, 32'h7c2bac1e, 32'h7c2bac20);
    waitDone(0);
    checkOutput("t2_status", done_status[0], 2'd0);
    checkOutput("t2_hashes", hashes_done[0], 32'd3);
    checkOutput("t2_found_count", fcount[0] - fbase, 0);
    checkOutput("t2_found_nonce_held", found_nonce[0], 32'h7c2bac1d);
    @(negedge clk);

    $display("[TB] test 3: wrap-around, report every hit");
    applyStimulus(1, GEN_PREFIX, ALL_ONES, 32'hfffffffe, 32'h00000001);
    waitDone(1);
    checkOutput("t3_status", done_status[1], 2'd1);
    checkOutput("t3_hashes", hashes_done[1], 32'd4);
    checkOutput("t3_found_count", fcount[1] - fbase, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_found_nonce_%0d", i), fn[1][fbase + i], t3_exp[i]);
    end
    @(negedge clk);

    $display("[TB] test 4: abort while a hit digest is in flight");
    applyStimulus(0, GEN_PREFIX, ALL_ONES, 32'd0, 32'd9);
    waitStart(0);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    waitDone(0);
    abort = 1'b0;
    checkOutput("t4_status", done_status[0], 2'd2);
    checkOutput("t4_hashes", hashes_done[0], 32'd1);
    checkOutput("t4_starts", start_cnt[0] - sbase, 1);
    checkOutput("t4_found_count", fcount[0] - fbase, 0);
    @(negedge clk);

    $display("[TB] test 5: hasher not ready in ISSUE, single-nonce job");
    hold_ready = 1'b1;
    applyStimulus(0, GEN_PREFIX, GEN_TARGET, 32'h7c2bac1d, 32'h7c2bac1d);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t5_start_low_%0d", i), hasher_start[0], 1'b0);
      checkOutput($sformatf("t5_header_%0d", i), hasher_header[0], {GEN_PREFIX, 32'h1dac2b7c});
      @(negedge clk);
    end
    hold_ready = 1'b0;
    #1;
    checkOutput("t5_start_released", hasher_start[0], 1'b1);
    waitDone(0);
    checkOutput("t5_status", done_status[0], 2'd1);
    checkOutput("t5_hashes", hashes_done[0], 32'd1);
    checkOutput("t5_starts", start_cnt[0] - sbase, 1);
    checkOutput("t5_found_nonce", found_nonce[0], 32'h7c2bac1d);
    @(negedge clk);

    $display("[TB] test 6: reset while waiting for a digest");
    applyStimulus(0, GEN_PREFIX, GEN_TARGET, 32'd0, 32'd9);
    repeat (3) @(negedge clk);
    checkOutput("t6_busy_before", busy[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_job_ready", job_ready[0], 1'b1);
    checkOutput("t6_busy", busy[0], 1'b0);
    checkOutput("t6_hashes_cleared", hashes_done[0], 32'd0);
    saw_done = done_valid[0];
    repeat (LAT + 2) begin
      @(negedge clk);
      saw_done = saw_done | done_valid[0];
    end
    checkOutput("t6_no_done", saw_done, 1'b0);
    applyStimulus(0, GEN_PREFIX, GEN_TARGET, 32'h7c2bac1c, 32'h7c2bac1d);
    waitDone(0);
    checkOutput("t6_status", done_status[0], 2'd1);
    checkOutput("t6_hashes", hashes_done[0], 32'd2);
    checkOutput("t6_found_nonce", found_nonce[0], 32'h7c2bac1d);
    @(negedge clk);

    checkOutput("start_protocol", proto_viol, 0);
    checkOutput("header_stable", header_viol, 0);
    checkOutput("found_done_apart", both_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
